// File: rtl/ram_n.sv
// ram_n: single-port word RAM with a self-timed clear sweep.
// Define RAM_N_READ_REG_EN for a registered (one-cycle) read port.
module ram_n #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [AW-1:0]    address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state, state_n;
  logic [AW-1:0]    counter, counter_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  assign busy = (state == CLEAR);

  // state and sweep counter; reset restarts the sweep at word 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
    end
  end

  // next state: clear beats load, sweep ends on the last word
  always_comb begin
    state_n   = state;
    counter_n = counter;
    unique case (state)
      IDLE: begin
        if (clear) begin
          state_n   = CLEAR;
          counter_n = '0;
        end
      end
      CLEAR: begin
        if (counter == LAST) begin
          state_n = IDLE;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
    endcase
  end

  // one write port shared by user writes and the sweep
  always_comb begin
    we    = 1'b0;
    waddr = address;
    wdata = in;
    if (!reset) begin
      if (busy) begin
        we    = 1'b1;
        waddr = counter;
        wdata = '0;
      end else if (load && !clear) begin
        we = 1'b1;
      end
    end
  end

  // array storage, no reset: the sweep zeroes it
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef RAM_N_READ_REG_EN
  logic [WIDTH-1:0] out_q;

  // registered read, old data on collision, zero after busy cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else if (busy) begin
      out_q <= '0;
    end else begin
      out_q <= mem[address];
    end
  end

  assign out = out_q;
`else
  assign out = busy ? '0 : mem[address];
`endif

endmodule

// File: tb/tb_ram_n.sv
// tb_ram_n: vectors, corner sequences and random traffic against
// a behavioural model of ram_n (WIDTH=16, DEPTH=8).
module tb_ram_n;

  localparam int W = 16;
  localparam int D = 8;

  logic          clk;
  logic          reset;
  logic [W-1:0]  in;
  logic          load;
  logic [2:0]    address;
  logic          clear;
  logic [W-1:0]  out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem_m [D];
  int           left;
  logic [W-1:0] oreg;

  typedef struct {
    logic         ld;
    logic [2:0]   adr;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [16];

  ram_n #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_out();
`ifdef RAM_N_READ_REG_EN
    return oreg;
`else
    return (left > 0) ? '0 : mem_m[address];
`endif
  endfunction

  // model of one rising edge with the currently driven inputs
  task automatic model_edge();
    if (reset) return;
    oreg = (left > 0) ? '0 : mem_m[address];
    if (left > 0) begin
      mem_m[D - left] = '0;
      left--;
    end else if (clear) begin
      left = D;
    end else if (load) begin
      mem_m[address] = in;
    end
  endtask

  // one cycle, entered and left at posedge+1
  task automatic step(input logic ld, input logic clr,
                      input logic [2:0] a, input logic [W-1:0] d);
    load = ld; clear = clr; address = a; in = d;
    @(negedge clk);
    chk("busy", W'(busy), W'(left > 0));
    chk("out", out, exp_out());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [W-1:0] exp,
                          input string nm);
    load = 1'b0; clear = 1'b0; address = a; in = '0;
`ifdef RAM_N_READ_REG_EN
    @(posedge clk);
    model_edge();
`endif
    @(negedge clk);
    chk(nm, out, exp);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // counts consecutive busy cycles with idle inputs
  task automatic count_busy(output int n);
    n = 0;
    load = 1'b0; clear = 1'b0; in = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      chk("out_busy", out, '0);
      n++;
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    left = D;
    oreg = '0;
    chk("rst_busy", W'(busy), W'(1));
    chk("rst_out", out, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; load = 1'b0; clear = 1'b0;
    address = '0; in = '0;
    for (int i = 0; i < D; i++) mem_m[i] = '0;
    left = D;
    oreg = '0;
    #1;
    chk("rst0_busy", W'(busy), W'(1));
    chk("rst0_out", out, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // power-up sweep
    count_busy(n);
    chk("sweep_len", W'(n), W'(8));
    for (int k = 0; k < D; k++) rd_check(3'(k), '0, "init_zero");

    // table: write 0x1111*k then read back
    for (int k = 0; k < D; k++) begin
      vecs[k].ld = 1'b1;
      vecs[k].adr = 3'(k);
      vecs[k].din = W'(16'h1111 * k);
      vecs[k].exp = '0;
      vecs[k+D].ld = 1'b0;
      vecs[k+D].adr = 3'(k);
      vecs[k+D].din = '0;
      vecs[k+D].exp = W'(16'h1111 * k);
    end
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].ld) step(1'b1, 1'b0, vecs[i].adr, vecs[i].din);
      else rd_check(vecs[i].adr, vecs[i].exp, "tbl_read");
    end

    // clear wins over a simultaneous load
    step(1'b1, 1'b1, 3'd3, 16'hBEEF);
    count_busy(n);
    chk("clr_len", W'(n), W'(8));
    rd_check(3'd3, '0, "clr_beats_load");
    rd_check(3'd7, '0, "clr_word7");

    // writes ignored during a sweep
    step(1'b1, 1'b0, 3'd5, 16'h5555);
    step(1'b0, 1'b1, 3'd0, '0);
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 3'd5, 16'hAAAA);
    chk("busy_end", W'(busy), W'(0));
    rd_check(3'd5, '0, "load_in_sweep");

    // reset in the middle of a sweep restarts it
    for (int k = 0; k < D; k++) step(1'b1, 1'b0, 3'(k), 16'hC0DE);
    step(1'b0, 1'b1, 3'd0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd6, '0);
    do_reset();
    count_busy(n);
    chk("rst_mid_len", W'(n), W'(8));
    for (int k = 0; k < D; k++) rd_check(3'(k), '0, "rst_mid_zero");

    // reset on a write edge drops that write
    step(1'b0, 1'b0, 3'd1, '0);
    load = 1'b1; address = 3'd1; in = 16'h7777;
    do_reset();
    count_busy(n);
    chk("rst_wr_len", W'(n), W'(8));
    rd_check(3'd1, '0, "rst_drops_write");

`ifdef RAM_N_READ_REG_EN
    step(1'b1, 1'b0, 3'd2, 16'h1234);
    step(1'b0, 1'b0, 3'd2, '0);
    load = 1'b1; address = 3'd2; in = 16'h5678;
    @(posedge clk); model_edge(); #1;
    chk("rbw_old", out, 16'h1234);
    load = 1'b0;
    @(posedge clk); model_edge(); #1;
    chk("rbw_new", out, 16'h5678);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 24) == 0),
           3'($urandom_range(0, D - 1)),
           W'($urandom));
    end
    for (int k = 0; k < D; k++) step(1'b0, 1'b0, 3'(k), '0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_n.md
RAM_N -- requirements
Module: ram_n

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 64, number of words (power of two, >=2); address width AW = log2(DEPTH), derived, not overridable.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in  input  WIDTH  write data.
REQ-006 load  input  1  write enable for word at address.
REQ-007 address  input  AW  read/write word address.
REQ-008 clear  input  1  request to zero the whole array.
REQ-009 out  output  WIDTH  read data.
REQ-010 busy  output  1  high while a clear sweep runs; writes ignored.

Function
REQ-011 The block SHALL have two states: IDLE and CLEAR, plus an AW-bit sweep counter.
REQ-012 In IDLE with load=1 and clear=0, mem[address] SHALL take in at the rising edge.
REQ-013 In IDLE with load=0, memory SHALL hold all words unchanged.
REQ-014 Without RAM_N_READ_REG_EN, out SHALL equal mem[address] combinationally in IDLE (zero read latency; a write is visible on out from the edge that performs it).
REQ-015 In IDLE with clear=1 at an edge, state SHALL move to CLEAR with counter=0; clear SHALL win over a simultaneous load, which SHALL be discarded.
REQ-016 In CLEAR, each edge SHALL write 0 to mem[counter] and increment counter; load and clear SHALL be ignored.
REQ-017 At the edge where counter=DEPTH-1, the final word SHALL be zeroed and state SHALL return to IDLE; a sweep SHALL last exactly DEPTH cycles.
REQ-018 busy SHALL be 1 exactly when state=CLEAR.
REQ-019 out SHALL be forced to 0 while busy=1.
REQ-020 Counter SHALL NOT wrap past DEPTH-1; no word SHALL be written twice in one sweep.
REQ-021 Address values are always in range (DEPTH is a power of two); no out-of-range handling SHALL exist.

Reset
REQ-022 Assertion of reset SHALL immediately set state=CLEAR, counter=0, busy=1, out=0, independent of clk.
REQ-023 After reset deasserts, the block SHALL perform a full DEPTH-cycle clear sweep, so all words read 0 when busy first falls.
REQ-024 Reset asserted mid-sweep or mid-write SHALL restart the sweep from word 0; the interrupted write SHALL be lost.

Configuration
REQ-025 Macro RAM_N_READ_REG_EN SHALL select a registered read port.
REQ-026 With RAM_N_READ_REG_EN defined, out SHALL be a register loaded with mem[address] each edge (one-cycle latency), read-before-write on same-address collision (old data), reset to 0, and 0 on the edge after any cycle with busy=1.
REQ-027 Without RAM_N_READ_REG_EN, out SHALL follow REQ-014 and no read register SHALL exist.

Verification (WIDTH=16, DEPTH=8)
REQ-028 Pulse reset, release -> busy=1 for exactly 8 cycles, out=0 throughout; then all 8 addresses read 0x0000.
REQ-029 After clear, write 0x1111*k to address k for k=0..7, read back each -> out=0x1111*k (same cycle; next cycle with RAM_N_READ_REG_EN).
REQ-030 Write 0xBEEF to address 3 with clear=1 on the same edge -> busy=1 for 8 cycles, then address 3 reads 0x0000.
REQ-031 Assert load=1, address=5, in=0xAAAA every cycle during a sweep -> after busy falls, address 5 reads 0x0000.
REQ-032 Assert reset at sweep cycle 4 for one cycle -> busy stays 1 for 8 full cycles after release; all words 0.
REQ-033 With RAM_N_READ_REG_EN, address 2 holding 0x1234, write 0x5678 to address 2 -> out=0x1234 the edge of write, 0x5678 the following edge.
